alu_operand_loader: RTL and testbench

Byte-serial front end that feeds the ALU result multiplexer: accepts an opcode byte then operand bytes A and B over an 8-bit valid/ready stream and presents them to the ALU datapath as one atomic update. One cycle later it captures the ALU's `Resultado` into a result register, asserts `Done`, and counts completed operations. Sits between the chip's 8-bit input pins and the ALU (adders, shifters, result mux).

---
 rtl/alu_pkg.sv | 51 +++++
 rtl/alu_operand_loader.sv | 200 ++++++++++++++++++++
 tb/tb_alu_operand_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU front end.
//   - ALU operation select codes, as driven on ALUControl.
//   - State encoding of the byte-serial operand loader.
//   - Helper decodes of the loader state, used for Ready and Busy.
// -----------------------------------------------------------------------------
package alu_pkg;

   // ALU operation select codes
   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_OR   = 3'b011;
   localparam logic [2:0] ALU_SHLA = 3'b100;
   localparam logic [2:0] ALU_SHRA = 3'b101;
   localparam logic [2:0] ALU_SHLB = 3'b110;
   localparam logic [2:0] ALU_SHRB = 3'b111;

   // Loader state encoding
   typedef enum logic [2:0] {
      LD_IDLE  = 3'd0,
      LD_GET_A = 3'd1,
      LD_GET_B = 3'd2,
      LD_EXEC  = 3'd3,
      LD_HOLD  = 3'd4
   } ld_state_e;

   // Every state except EXEC can accept a byte
   function automatic logic ld_accepts(input ld_state_e s);
      logic r;
      case (s)
         LD_IDLE, LD_GET_A, LD_GET_B, LD_HOLD: r = 1'b1;
         LD_EXEC:                              r = 1'b0;
         default:                              r = 1'b0;
      endcase
      return r;
   endfunction

   // An operation is in flight from the opcode until the result is captured
   function automatic logic ld_busy(input ld_state_e s);
      logic r;
      case (s)
         LD_GET_A, LD_GET_B, LD_EXEC: r = 1'b1;
         LD_IDLE, LD_HOLD:            r = 1'b0;
         default:                     r = 1'b0;
      endcase
      return r;
   endfunction

endpackage : alu_pkg

// File: rtl/alu_operand_loader.sv
// -----------------------------------------------------------------------------
// alu_operand_loader
// Byte-serial front end for the ALU result multiplexer. Takes an opcode byte,
// then operand A, then operand B over an 8-bit valid/ready stream, loads
// A/B/ALUControl together on the B byte, and one cycle later captures the
// ALU's combinational result, raises Done and bumps the operation counter.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   DataIn     in   stream byte (opcode, A or B)
//   Valid      in   DataIn holds a byte
//   Ready      out  loader takes a byte this cycle (low only in EXEC)
//   A          out  operand A to the ALU
//   B          out  operand B to the ALU
//   ALUControl out  operation select to the ALU
//   Resultado  in   combinational ALU result for current A/B/ALUControl
//   Result     out  captured result of the last completed operation
//   Done       out  Result belongs to the most recent operation
//   Busy       out  operation partially loaded or executing
//   OpCount    out  completed operations, modulo 256
// -----------------------------------------------------------------------------
module alu_operand_loader
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] DataIn,
   input  logic       Valid,
   output logic       Ready,
   output logic [7:0] A,
   output logic [7:0] B,
   output logic [2:0] ALUControl,
   input  logic [7:0] Resultado,
   output logic [7:0] Result,
   output logic       Done,
   output logic       Busy,
   output logic [7:0] OpCount
);

   ld_state_e  state_q, state_d;

   logic [2:0] op_pend_q, op_pend_d;
   logic [7:0] a_pend_q,  a_pend_d;
   logic [7:0] a_q,       a_d;
   logic [7:0] b_q,       b_d;
   logic [2:0] ctl_q,     ctl_d;
   logic [7:0] result_q,  result_d;
   logic       done_q,    done_d;
   logic [7:0] count_q,   count_d;

   logic       ready_s;
   logic       busy_s;
   logic       xfer_s;
   logic       take_op_s;
   logic       take_a_s;
   logic       take_b_s;
   logic       exec_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= LD_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a byte moves only when Valid meets Ready
   always_comb begin
      state_d = state_q;
      case (state_q)
         LD_IDLE, LD_HOLD: begin
            if (xfer_s) begin
               state_d = LD_GET_A;
            end else begin
               state_d = state_q;
            end
         end
         LD_GET_A: begin
            if (xfer_s) begin
               state_d = LD_GET_B;
            end else begin
               state_d = LD_GET_A;
            end
         end
         LD_GET_B: begin
            if (xfer_s) begin
               state_d = LD_EXEC;
            end else begin
               state_d = LD_GET_B;
            end
         end
         LD_EXEC: state_d = LD_HOLD;
         default: state_d = LD_IDLE;
      endcase
   end

   // State decodes: handshake outputs and per-state load strobes
   always_comb begin
      ready_s   = ld_accepts(state_q);
      busy_s    = ld_busy(state_q);
      xfer_s    = Valid & ready_s;
      take_op_s = 1'b0;
      take_a_s  = 1'b0;
      take_b_s  = 1'b0;
      exec_s    = 1'b0;
      case (state_q)
         LD_IDLE, LD_HOLD: take_op_s = xfer_s;
         LD_GET_A:         take_a_s  = xfer_s;
         LD_GET_B:         take_b_s  = xfer_s;
         LD_EXEC:          exec_s    = 1'b1;
         default: begin
            take_op_s = 1'b0;
            take_a_s  = 1'b0;
            take_b_s  = 1'b0;
            exec_s    = 1'b0;
         end
      endcase
   end

   // Datapath next values. A, B and ALUControl change together on the B
   // byte only, so the ALU never sees a mixed old/new operand set.
   always_comb begin
      op_pend_d = op_pend_q;
      a_pend_d  = a_pend_q;
      a_d       = a_q;
      b_d       = b_q;
      ctl_d     = ctl_q;
      result_d  = result_q;
      done_d    = done_q;
      count_d   = count_q;

      if (take_op_s) begin
         // Upper opcode bits are don't-care
         op_pend_d = DataIn[2:0];
         done_d    = 1'b0;
      end else begin
         op_pend_d = op_pend_q;
      end

      if (take_a_s) begin
         a_pend_d = DataIn;
      end else begin
         a_pend_d = a_pend_q;
      end

      if (take_b_s) begin
         a_d   = a_pend_q;
         b_d   = DataIn;
         ctl_d = op_pend_q;
      end else begin
         a_d   = a_q;
         b_d   = b_q;
         ctl_d = ctl_q;
      end

      if (exec_s) begin
         result_d = Resultado;
         done_d   = 1'b1;
         count_d  = count_q + 8'd1;
      end else begin
         result_d = result_q;
         count_d  = count_q;
      end
   end

   // Datapath registers; reset drops any partially loaded operation
   always_ff @(posedge clk) begin
      if (rst) begin
         op_pend_q <= ALU_ADD;
         a_pend_q  <= 8'h00;
         a_q       <= 8'h00;
         b_q       <= 8'h00;
         ctl_q     <= ALU_ADD;
         result_q  <= 8'h00;
         done_q    <= 1'b0;
         count_q   <= 8'h00;
      end else begin
         op_pend_q <= op_pend_d;
         a_pend_q  <= a_pend_d;
         a_q       <= a_d;
         b_q       <= b_d;
         ctl_q     <= ctl_d;
         result_q  <= result_d;
         done_q    <= done_d;
         count_q   <= count_d;
      end
   end

   assign Ready      = ready_s;
   assign Busy       = busy_s;
   assign A          = a_q;
   assign B          = b_q;
   assign ALUControl = ctl_q;
   assign Result     = result_q;
   assign Done       = done_q;
   assign OpCount    = count_q;

endmodule : alu_operand_loader

// File: tb/tb_alu_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_loader
// Directed bench for alu_operand_loader with a small behavioural ALU driving
// Resultado. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_operand_loader;

   logic       clk;
   logic       rst;
   logic [7:0] DataIn;
   logic       Valid;
   logic       Ready;
   logic [7:0] A;
   logic [7:0] B;
   logic [2:0] ALUControl;
   logic [7:0] Resultado;
   logic [7:0] Result;
   logic       Done;
   logic       Busy;
   logic [7:0] OpCount;

   int tests_run;
   int tests_failed;
   int stall_cycles;
   int cycle_cnt;
   int exp_count;

   alu_operand_loader dut (
      .clk        (clk),
      .rst        (rst),
      .DataIn     (DataIn),
      .Valid      (Valid),
      .Ready      (Ready),
      .A          (A),
      .B          (B),
      .ALUControl (ALUControl),
      .Resultado  (Resultado),
      .Result     (Result),
      .Done       (Done),
      .Busy       (Busy),
      .OpCount    (OpCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: shifts are by one position
   always_comb begin
      case (ALUControl)
         3'b000:  Resultado = A + B;
         3'b001:  Resultado = A - B;
         3'b010:  Resultado = A & B;
         3'b011:  Resultado = A | B;
         3'b100:  Resultado = A << 1;
         3'b101:  Resultado = A >> 1;
         3'b110:  Resultado = B << 1;
         3'b111:  Resultado = B >> 1;
         default: Resultado = 8'h00;
      endcase
   end

   // Edge counter and count of edges where a byte was offered but refused
   always @(posedge clk) begin
      cycle_cnt <= cycle_cnt + 1;
      if (Valid && !Ready) stall_cycles <= stall_cycles + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte transferred
   task automatic send_byte(input logic [7:0] b);
      int waitc;
      waitc  = 0;
      DataIn = b;
      Valid  = 1'b1;
      while (!Ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (!Ready) check_eq("ready_timeout", 32'(waitc), 32'd0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      Valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_count = 0;
   endtask

   // One full operation with Valid dropped after B
   task automatic do_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] ctl, input logic [7:0] res);
      send_byte(op);
      check_eq({tag, "_done_clr"}, 32'(Done), 32'd0);
      check_eq({tag, "_busy"},     32'(Busy), 32'd1);
      send_byte(a);
      send_byte(b);
      Valid = 1'b0;
      check_eq({tag, "_A"},    32'(A), 32'(a));
      check_eq({tag, "_B"},    32'(B), 32'(b));
      check_eq({tag, "_ctl"},  32'(ALUControl), 32'(ctl));
      check_eq({tag, "_exec_ready"}, 32'(Ready), 32'd0);
      check_eq({tag, "_exec_done"},  32'(Done),  32'd0);
      @(negedge clk);
      exp_count = (exp_count + 1) % 256;
      check_eq({tag, "_done"},   32'(Done),    32'd1);
      check_eq({tag, "_result"}, 32'(Result),  32'(res));
      check_eq({tag, "_count"},  32'(OpCount), 32'(exp_count));
      check_eq({tag, "_idle"},   32'(Busy),    32'd0);
   endtask

   logic [7:0] s_op  [4] = '{8'h00, 8'h01, 8'h03, 8'h02};
   logic [7:0] s_a   [4] = '{8'h10, 8'h05, 8'h0F, 8'hAA};
   logic [7:0] s_b   [4] = '{8'h20, 8'h06, 8'hF0, 8'h0F};
   logic [7:0] s_res [4] = '{8'h30, 8'hFF, 8'hFF, 8'h0A};

   initial begin
      int t0;
      int s0;
      tests_run    = 0;
      tests_failed = 0;
      stall_cycles = 0;
      cycle_cnt    = 0;
      exp_count    = 0;
      DataIn       = 8'h00;
      Valid        = 1'b0;
      rst          = 1'b1;

      // Reset state
      do_reset();
      check_eq("rst_A",     32'(A), 32'h00);
      check_eq("rst_B",     32'(B), 32'h00);
      check_eq("rst_ctl",   32'(ALUControl), 32'h0);
      check_eq("rst_res",   32'(Result), 32'h00);
      check_eq("rst_done",  32'(Done), 32'd0);
      check_eq("rst_busy",  32'(Busy), 32'd0);
      check_eq("rst_ready", 32'(Ready), 32'd1);
      check_eq("rst_cnt",   32'(OpCount), 32'h00);

      // Directed operations
      do_op("add",  8'h00, 8'h05, 8'h03, 3'b000, 8'h08);
      do_op("sub",  8'hF9, 8'hF0, 8'h3C, 3'b001, 8'hB4);
      do_op("and",  8'h02, 8'hF0, 8'h3C, 3'b010, 8'h30);
      do_op("or",   8'h03, 8'hA0, 8'h05, 3'b011, 8'hA5);
      do_op("shla", 8'h04, 8'h81, 8'h00, 3'b100, 8'h02);
      do_op("shrb", 8'hFF, 8'h12, 8'h80, 3'b111, 8'h40);

      // Stall between A and B: outputs hold the previous operation
      send_byte(8'h01);
      send_byte(8'h50);
      Valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("stall_busy", 32'(Busy), 32'd1);
         check_eq("stall_A",    32'(A), 32'h12);
         check_eq("stall_B",    32'(B), 32'h80);
         check_eq("stall_ctl",  32'(ALUControl), 32'h7);
      end
      send_byte(8'h20);
      Valid = 1'b0;
      @(negedge clk);
      exp_count++;
      check_eq("stall_res",  32'(Result), 32'h30);
      check_eq("stall_done", 32'(Done), 32'd1);
      check_eq("stall_cnt",  32'(OpCount), 32'(exp_count));

      // Continuous stream, Valid never drops: 4 cycles and 1 stall per op
      t0 = cycle_cnt;
      s0 = stall_cycles;
      for (int i = 0; i < 4; i++) begin
         send_byte(s_op[i]);
         send_byte(s_a[i]);
         send_byte(s_b[i]);
         // During EXEC present the next opcode (or junk on the last op)
         DataIn = (i < 3) ? s_op[i + 1] : 8'hEE;
         @(negedge clk);
         exp_count++;
         check_eq("strm_done",  32'(Done), 32'd1);
         check_eq("strm_res",   32'(Result), 32'(s_res[i]));
         check_eq("strm_ready", 32'(Ready), 32'd1);
      end
      Valid = 1'b0;
      check_eq("strm_cycles", 32'(cycle_cnt - t0), 32'd16);
      check_eq("strm_stalls", 32'(stall_cycles - s0), 32'd4);
      check_eq("strm_cnt",    32'(OpCount), 32'(exp_count));

      // Reset while a B byte is offered in GET_B
      send_byte(8'h00);
      send_byte(8'h77);
      DataIn = 8'h11;
      Valid  = 1'b1;
      rst    = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      Valid = 1'b0;
      exp_count = 0;
      check_eq("mid_rst_ready", 32'(Ready), 32'd1);
      check_eq("mid_rst_busy",  32'(Busy), 32'd0);
      check_eq("mid_rst_A",     32'(A), 32'h00);
      check_eq("mid_rst_B",     32'(B), 32'h00);
      check_eq("mid_rst_ctl",   32'(ALUControl), 32'h0);
      check_eq("mid_rst_res",   32'(Result), 32'h00);
      check_eq("mid_rst_done",  32'(Done), 32'd0);
      check_eq("mid_rst_cnt",   32'(OpCount), 32'h00);
      do_op("fresh", 8'h01, 8'h09, 8'h04, 3'b001, 8'h05);

      // 256 back-to-back operations wrap the counter
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send_byte(8'h00);
         send_byte(8'(i));
         send_byte(8'h01);
         DataIn = 8'h00;
         @(negedge clk);
         if (i == 254) check_eq("wrap_255", 32'(OpCount), 32'hFF);
      end
      Valid = 1'b0;
      check_eq("wrap_cnt",  32'(OpCount), 32'h00);
      check_eq("wrap_done", 32'(Done), 32'd1);
      check_eq("wrap_res",  32'(Result), 32'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_alu_operand_loader
